// File: rtl/bullet_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_launcher
//  Description : Fire-interface initiator for a pool of bullet FSMs. It emits
//                periodic fan-shaped volleys from a movable origin, picking
//                the lowest idle bullet for each shot and driving the shared
//                launch bus together with a one-hot fire pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_launcher #(
  parameter int N_BULLETS   = 8,
  parameter int PERIOD      = 25,
  parameter int BURST_LEN   = 5,
  parameter int PAT_LEN     = 5,
  parameter int VX_16X      = 32,
  parameter int VY_STEP_16X = 8
) (
  input  logic                        clk_100Hz,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [9:0]                  x_origin,
  input  logic [8:0]                  y_origin,
  input  logic [N_BULLETS-1:0]        bullet_state,
  output logic [N_BULLETS-1:0]        fire,
  output logic [9:0]                  x_dout,
  output logic [8:0]                  y_dout,
  output logic [7:0]                  vx_dout_16x,
  output logic signed [12:0]          vy_dout_16x,
  output logic [15:0]                 shots_fired,
  output logic [7:0]                  shots_dropped,
  output logic                        busy
);

  localparam int CNT_W    = (PERIOD > 1)    ? $clog2(PERIOD)    : 1;
  localparam int SHOT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PAT_W    = (PAT_LEN > 1)   ? $clog2(PAT_LEN)   : 1;
  localparam int PAT_HALF = (PAT_LEN - 1) / 2;

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(PERIOD - 1);
  localparam logic [SHOT_W-1:0] SHOT_LAST  = SHOT_W'(BURST_LEN - 1);
  localparam logic [PAT_W-1:0]  PAT_LAST   = PAT_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SHOT_W-1:0]      shot_cnt_q, shot_cnt_d;
  logic [PAT_W-1:0]       pat_idx_q, pat_idx_d;
  logic [N_BULLETS-1:0]   fire_q, fire_d;
  logic [9:0]             x_q, x_d;
  logic [8:0]             y_q, y_d;
  logic [7:0]             vx_q, vx_d;
  logic signed [12:0]     vy_q, vy_d;
  logic [15:0]            fired_q, fired_d;
  logic [7:0]             dropped_q, dropped_d;
  logic                   busy_q, busy_d;

  logic [N_BULLETS-1:0]   eligible;
  logic [N_BULLETS-1:0]   lowest_eligible;
  logic signed [12:0]     vy_slot;
  logic signed [12:0]     vy_calc;

  // Idle-bullet selection and fan-slot velocity for the current shot.
  // A bullet pulsed last cycle still reads idle, so the live fire mask
  // excludes it until its state bit catches up.
  always_comb begin
    eligible        = ~bullet_state & ~fire_q;
    lowest_eligible = eligible & (~eligible + N_BULLETS'(1));
    vy_slot         = $signed(13'(pat_idx_q)) - $signed(13'(PAT_HALF));
    vy_calc         = vy_slot * $signed(13'(VY_STEP_16X));
  end

  // Next-state and output logic; enable low forces IDLE with no shot.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shot_cnt_d = shot_cnt_q;
    pat_idx_d  = pat_idx_q;
    fire_d     = '0;
    x_d        = x_q;
    y_d        = y_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    fired_d    = fired_q;
    dropped_d  = dropped_q;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = CNT_RELOAD;
        end
        COUNT: begin
          if (cnt_q == '0) begin
            state_d    = BURST;
            shot_cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        BURST: begin
          if (|eligible) begin
            fire_d  = lowest_eligible;
            x_d     = x_origin;
            y_d     = y_origin;
            vx_d    = 8'(VX_16X);
            vy_d    = vy_calc;
            fired_d = fired_q + 16'd1;
          end else if (dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
          end
          pat_idx_d  = (pat_idx_q == PAT_LAST) ? '0 : pat_idx_q + PAT_W'(1);
          shot_cnt_d = shot_cnt_q + SHOT_W'(1);
          if (shot_cnt_q == SHOT_LAST) begin
            state_d = COUNT;
            cnt_d   = CNT_RELOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shot_cnt_q <= '0;
      pat_idx_q  <= '0;
      fire_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      fired_q    <= '0;
      dropped_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shot_cnt_q <= shot_cnt_d;
      pat_idx_q  <= pat_idx_d;
      fire_q     <= fire_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      fired_q    <= fired_d;
      dropped_q  <= dropped_d;
      busy_q     <= busy_d;
    end
  end

  assign fire          = fire_q;
  assign x_dout        = x_q;
  assign y_dout        = y_q;
  assign vx_dout_16x   = vx_q;
  assign vy_dout_16x   = vy_q;
  assign shots_fired   = fired_q;
  assign shots_dropped = dropped_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bullet_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_launcher
//  Description : Self-checking bench for bullet_launcher: directed volley
//                table, multi-cycle corner sequences, and randomized traffic
//                against a schedule-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bullet_launcher;

  localparam int P   = 25;
  localparam int B   = 5;
  localparam int PL  = 5;
  localparam int VX  = 32;
  localparam int VYS = 8;

  logic              clk_100Hz = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [9:0]        x_origin = '0;
  logic [8:0]        y_origin = '0;
  logic [7:0]        bullet_state = '0;
  logic [7:0]        fire;
  logic [9:0]        x_dout;
  logic [8:0]        y_dout;
  logic [7:0]        vx_dout_16x;
  logic signed [12:0] vy_dout_16x;
  logic [15:0]       shots_fired;
  logic [7:0]        shots_dropped;
  logic              busy;

  bullet_launcher dut (
    .clk_100Hz     (clk_100Hz),
    .rst           (rst),
    .enable        (enable),
    .x_origin      (x_origin),
    .y_origin      (y_origin),
    .bullet_state  (bullet_state),
    .fire          (fire),
    .x_dout        (x_dout),
    .y_dout        (y_dout),
    .vx_dout_16x   (vx_dout_16x),
    .vy_dout_16x   (vy_dout_16x),
    .shots_fired   (shots_fired),
    .shots_dropped (shots_dropped),
    .busy          (busy)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_bs  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Reference model: shot slots follow from how many consecutive edges
  // enable has been high (k). Edge k=1 leaves idle; shots occur at
  // k = P+2 .. P+1+B, repeating every P+B edges.
  int         m_k, m_pat, m_fired, m_drop, m_vy;
  logic [7:0] m_fire, m_vx;
  logic [9:0] m_x;
  logic [8:0] m_y;
  bit         m_busy;

  task automatic model_step();
    logic [7:0] elig;
    bit found;
    if (rst) begin
      m_k = 0; m_pat = 0; m_fired = 0; m_drop = 0; m_vy = 0;
      m_fire = 0; m_vx = 0; m_x = 0; m_y = 0; m_busy = 0;
    end else if (!enable) begin
      m_k = 0; m_fire = 0; m_busy = 0;
    end else begin
      m_k++;
      m_busy = 1;
      if (m_k >= P + 2 && ((m_k - (P + 2)) % (P + B)) < B) begin
        elig  = ~bullet_state & ~m_fire;
        m_fire = 0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
          if (elig[i] && !found) begin
            m_fire[i] = 1'b1;
            found = 1;
          end
        end
        if (found) begin
          m_x = x_origin; m_y = y_origin; m_vx = 8'(VX);
          m_vy = (m_pat - (PL - 1) / 2) * VYS;
          m_fired = (m_fired + 1) % 65536;
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_pat = (m_pat + 1) % PL;
      end else begin
        m_fire = 0;
      end
    end
  endtask

  // One clock: step the model on the inputs the DUT samples, then let the
  // bullet pool raise the state of whatever was pulsed before the edge.
  task automatic tick();
    logic [7:0] f;
    f = fire;
    model_step();
    @(posedge clk_100Hz);
    #1;
    if (auto_bs) bullet_state = bullet_state | f;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cmp_model();
    chk("m_fire",  64'(fire),          64'(m_fire));
    chk("m_x",     64'(x_dout),        64'(m_x));
    chk("m_y",     64'(y_dout),        64'(m_y));
    chk("m_vx",    64'(vx_dout_16x),   64'(m_vx));
    chk("m_vy",    longint'(vy_dout_16x), longint'(m_vy));
    chk("m_fired", 64'(shots_fired),   64'(m_fired));
    chk("m_drop",  64'(shots_dropped), 64'(m_drop));
    chk("m_busy",  64'(busy),          64'(m_busy));
  endtask

  typedef struct {
    logic [7:0]      bs;
    logic [4:0][7:0] f;
    int              nfired;
    int              ndrop;
  } vec_t;

  vec_t       vecs[5];
  int         vy_tab[5] = '{-16, -8, 0, 8, 16};
  logic [9:0] last_x;
  logic [8:0] last_y;
  logic [7:0] f2[5];

  initial begin
    vecs[0].bs = 8'h00; vecs[0].f = {8'h10, 8'h08, 8'h04, 8'h02, 8'h01}; vecs[0].nfired = 5; vecs[0].ndrop = 0;
    vecs[1].bs = 8'hF5; vecs[1].f = {8'h00, 8'h00, 8'h00, 8'h08, 8'h02}; vecs[1].nfired = 2; vecs[1].ndrop = 3;
    vecs[2].bs = 8'hFF; vecs[2].f = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].nfired = 0; vecs[2].ndrop = 5;
    vecs[3].bs = 8'h7F; vecs[3].f = {8'h00, 8'h00, 8'h00, 8'h00, 8'h80}; vecs[3].nfired = 1; vecs[3].ndrop = 4;
    vecs[4].bs = 8'hAA; vecs[4].f = {8'h00, 8'h40, 8'h10, 8'h04, 8'h01}; vecs[4].nfired = 4; vecs[4].ndrop = 1;
    f2 = '{8'h20, 8'h40, 8'h80, 8'h00, 8'h00};

    // Reset state
    do_reset();
    chk("rst_fire", 64'(fire), 0);
    chk("rst_x", 64'(x_dout), 0);
    chk("rst_y", 64'(y_dout), 0);
    chk("rst_vx", 64'(vx_dout_16x), 0);
    chk("rst_vy", longint'(vy_dout_16x), 0);
    chk("rst_fired", 64'(shots_fired), 0);
    chk("rst_drop", 64'(shots_dropped), 0);
    chk("rst_busy", 64'(busy), 0);

    // Table: one full volley from reset per bullet-pool pattern
    for (int r = 0; r < 5; r++) begin
      do_reset();
      auto_bs = 1'b1;
      bullet_state = vecs[r].bs;
      x_origin = 10'(100 + r * 10);
      y_origin = 9'(50 + r);
      last_x = '0; last_y = '0;
      enable = 1'b1;
      tick();
      chk("busy_after_en", 64'(busy), 1);
      repeat (25) tick();
      chk("pre_shot_fire", 64'(fire), 0);
      for (int s = 0; s < 5; s++) begin
        tick();
        chk("tbl_fire", 64'(fire), 64'(vecs[r].f[s]));
        if (vecs[r].f[s] != 8'h00) begin
          chk("tbl_x", 64'(x_dout), 64'(x_origin));
          chk("tbl_y", 64'(y_dout), 64'(y_origin));
          chk("tbl_vx", 64'(vx_dout_16x), 64'(VX));
          chk("tbl_vy", longint'(vy_dout_16x), longint'(vy_tab[s]));
          last_x = x_origin; last_y = y_origin;
        end else begin
          chk("tbl_hold_x", 64'(x_dout), 64'(last_x));
          chk("tbl_hold_y", 64'(y_dout), 64'(last_y));
        end
      end
      chk("tbl_fired", 64'(shots_fired), 64'(vecs[r].nfired));
      chk("tbl_drop", 64'(shots_dropped), 64'(vecs[r].ndrop));
    end

    // Second volley continues the fan and finds only three idle bullets
    do_reset();
    auto_bs = 1'b1; bullet_state = 8'h00; enable = 1'b1;
    repeat (27) tick();
    chk("v1_first", 64'(fire), 8'h01);
    repeat (4) tick();
    chk("v1_fired", 64'(shots_fired), 5);
    repeat (25) tick();
    chk("v2_gap", 64'(fire), 0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("v2_fire", 64'(fire), 64'(f2[s]));
      if (f2[s] != 8'h00) chk("v2_vy", longint'(vy_dout_16x), longint'(vy_tab[s]));
    end
    chk("v2_drop", 64'(shots_dropped), 2);
    chk("v2_fired", 64'(shots_fired), 8);

    // Enable dropped after two shots, then restarted
    do_reset();
    auto_bs = 1'b1; bullet_state = 8'h00; enable = 1'b1;
    repeat (28) tick();
    chk("en_shot2", 64'(fire), 8'h02);
    enable = 1'b0;
    tick();
    chk("en_off_fire", 64'(fire), 0);
    chk("en_off_busy", 64'(busy), 0);
    chk("en_off_fired", 64'(shots_fired), 2);
    enable = 1'b1;
    repeat (26) tick();
    chk("en_re_wait", 64'(fire), 0);
    tick();
    chk("en_re_fire", 64'(fire), 8'h04);
    chk("en_re_vy", longint'(vy_dout_16x), 0);

    // Reset in the middle of a burst
    do_reset();
    auto_bs = 1'b1; bullet_state = 8'h00;
    x_origin = 10'd320; y_origin = 9'd200; enable = 1'b1;
    repeat (28) tick();
    chk("mr_shot2", 64'(fire), 8'h02);
    rst = 1'b1;
    tick();
    chk("mr_fire", 64'(fire), 0);
    chk("mr_x", 64'(x_dout), 0);
    chk("mr_y", 64'(y_dout), 0);
    chk("mr_vx", 64'(vx_dout_16x), 0);
    chk("mr_vy", longint'(vy_dout_16x), 0);
    chk("mr_fired", 64'(shots_fired), 0);
    chk("mr_busy", 64'(busy), 0);
    rst = 1'b0; bullet_state = 8'h00;
    repeat (26) tick();
    chk("mr_wait", 64'(fire), 0);
    tick();
    chk("mr_first", 64'(fire), 8'h01);
    chk("mr_first_x", 64'(x_dout), 320);
    chk("mr_first_y", 64'(y_dout), 200);
    chk("mr_first_vy", longint'(vy_dout_16x), -16);

    // Drop counter saturation with every bullet in flight
    do_reset();
    auto_bs = 1'b0; bullet_state = 8'hFF; enable = 1'b1;
    repeat (27 + 30 * 52) tick();
    chk("sat_drop", 64'(shots_dropped), 255);
    chk("sat_fired", 64'(shots_fired), 0);
    chk("sat_fire", 64'(fire), 0);

    // Randomized traffic against the reference model
    do_reset();
    auto_bs = 1'b1; bullet_state = 8'h00; enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      x_origin = 10'($urandom);
      y_origin = 9'($urandom);
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 15) == 0) bullet_state[i] = 1'b0;
      tick();
      cmp_model();
      if (n_fail > 40) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
